// File: rtl/ip_decoder.sv
// ip_decoder - receive-side IPv4 header parser.
//
// Takes a packet as a stream of 32-bit big-endian words, one per clock,
// starting with the word qualified by start. Header fields are captured into
// registered outputs. The header checksum is verified, and payload words are
// forwarded with a write strobe when the checksum is good.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   data[31:0]     packet word, byte 0 in data[31:24]
//   start          marks word 0 of a new packet (sampled only while idle)
//   version, IHL, type_of_ser, total_length         word 0 fields
//   identification, flag, frag_offset                word 1 fields
//   time_to_live, protocol                           word 2 fields
//   src_ip, dest_ip                                  words 3 and 4
//   len_out        payload length in bytes (total_length - 4*IHL, floored at 0)
//   data_out       forwarded payload word
//   wr_en          data_out valid strobe
//   ok             header checksum valid
//   fin            one-cycle end-of-packet pulse
module ip_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        start,
  output logic [3:0]  version,
  output logic [3:0]  IHL,
  output logic [7:0]  type_of_ser,
  output logic [15:0] total_length,
  output logic [15:0] identification,
  output logic [2:0]  flag,
  output logic [12:0] frag_offset,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic [15:0] len_out,
  output logic [31:0] data_out,
  output logic        wr_en,
  output logic        ok,
  output logic        fin
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] OPTIONS = 2'd2;
  localparam logic [1:0] PAYLOAD = 2'd3;

  logic [1:0]  state;
  logic [3:0]  word_idx;
  logic [14:0] words_left;
  logic [20:0] sum_acc;
  logic [15:0] head_chks16;
  logic        hdr_done;
  logic        len_bad;

  logic [20:0] sum_next;
  logic [16:0] fold1;
  logic [15:0] sum_fold;
  logic [15:0] ihl_bytes;
  logic        w0_short;
  logic [15:0] w0_len;
  logic        last_hdr;
  logic [14:0] pay_words;

  // Running 21-bit sum of all header halves; two end-around folds are
  // enough because after the first fold the carry can be at most 1.
  always_comb begin
    sum_next  = sum_acc + {5'd0, data[31:16]} + {5'd0, data[15:0]};
    fold1     = {1'b0, sum_next[15:0]} + {12'd0, sum_next[20:16]};
    sum_fold  = fold1[15:0] + {15'd0, fold1[16]};
    ihl_bytes = {10'd0, data[27:24], 2'b00};
    w0_short  = data[15:0] < ihl_bytes;
    w0_len    = w0_short ? 16'd0 : (data[15:0] - ihl_bytes);
    last_hdr  = (word_idx == (IHL - 4'd1));
    pay_words = {1'b0, len_out[15:2]} + {14'd0, |len_out[1:0]};
  end

  // ok is derived from the stored folded sum so it holds naturally until
  // the next start clears hdr_done.
  assign ok = hdr_done && (head_chks16 == 16'hFFFF) && !len_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      word_idx       <= '0;
      words_left     <= '0;
      sum_acc        <= '0;
      head_chks16    <= '0;
      hdr_done       <= 1'b0;
      len_bad        <= 1'b0;
      version        <= '0;
      IHL            <= '0;
      type_of_ser    <= '0;
      total_length   <= '0;
      identification <= '0;
      flag           <= '0;
      frag_offset    <= '0;
      time_to_live   <= '0;
      protocol       <= '0;
      src_ip         <= '0;
      dest_ip        <= '0;
      len_out        <= '0;
      data_out       <= '0;
      wr_en          <= 1'b0;
      fin            <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      fin   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            version      <= data[31:28];
            IHL          <= data[27:24];
            type_of_ser  <= data[23:16];
            total_length <= data[15:0];
            len_out      <= w0_len;
            len_bad      <= w0_short;
            hdr_done     <= 1'b0;
            sum_acc      <= {5'd0, data[31:16]} + {5'd0, data[15:0]};
            word_idx     <= 4'd1;
            // A header shorter than five words cannot be parsed; end the
            // packet immediately with ok left low.
            if (data[27:24] < 4'd5) begin
              fin <= 1'b1;
            end else begin
              state <= HEADER;
            end
          end
        end
        HEADER, OPTIONS: begin
          case (word_idx)
            4'd1: begin
              identification <= data[31:16];
              flag           <= data[15:13];
              frag_offset    <= data[12:0];
            end
            4'd2: begin
              time_to_live <= data[31:24];
              protocol     <= data[23:16];
            end
            4'd3: src_ip  <= data;
            4'd4: dest_ip <= data;
            default: ;
          endcase
          sum_acc  <= sum_next;
          word_idx <= word_idx + 4'd1;
          if (last_hdr) begin
            head_chks16 <= sum_fold;
            hdr_done    <= 1'b1;
            if (len_out == 16'd0) begin
              fin   <= 1'b1;
              state <= IDLE;
            end else begin
              words_left <= pay_words;
              state      <= PAYLOAD;
            end
          end else if (word_idx == 4'd4) begin
            state <= OPTIONS;
          end
        end
        PAYLOAD: begin
          data_out   <= data;
          wr_en      <= ok;
          words_left <= words_left - 15'd1;
          if (words_left == 15'd1) begin
            fin   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_decoder.sv
// tb_ip_decoder - self-checking bench for ip_decoder.
//
// Directed packets (nominal, bad checksum, options, no payload, malformed
// IHL, reset mid-payload, back-to-back) followed by randomized packets. A
// reference model derives the expected field values, checksum verdict,
// payload strobes and fin timing from the IPv4 rules directly.
module tb_ip_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data = '0;
  logic        start = 1'b0;
  logic [3:0]  version, IHL;
  logic [7:0]  type_of_ser, time_to_live, protocol;
  logic [15:0] total_length, identification, len_out;
  logic [2:0]  flag;
  logic [12:0] frag_offset;
  logic [31:0] src_ip, dest_ip, data_out;
  logic        wr_en, ok, fin;

  int checks = 0;
  int errors = 0;

  ip_decoder dut (
    .clk(clk), .reset(reset), .data(data), .start(start),
    .version(version), .IHL(IHL), .type_of_ser(type_of_ser),
    .total_length(total_length), .identification(identification),
    .flag(flag), .frag_offset(frag_offset), .time_to_live(time_to_live),
    .protocol(protocol), .src_ip(src_ip), .dest_ip(dest_ip),
    .len_out(len_out), .data_out(data_out), .wr_en(wr_en), .ok(ok), .fin(fin)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one word, clock it in, and settle 1 ns past the edge.
  task automatic applyStimulus(input logic s, input logic [31:0] d);
    start = s;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  // Ones'-complement sum over the first n header words.
  function automatic logic [15:0] onesSum(input logic [31:0] w[$], input int n);
    int unsigned acc = 0;
    for (int i = 0; i < n; i++) acc += w[i][31:16] + w[i][15:0];
    while ((acc >> 16) != 0) acc = (acc & 32'hFFFF) + (acc >> 16);
    return acc[15:0];
  endfunction

  // Checksum value that makes the header sum come out to FFFF.
  function automatic logic [15:0] calcChecksum(input logic [31:0] w[$]);
    logic [31:0] tmp[$];
    tmp = w;
    tmp[2] = {w[2][31:16], 16'h0000};
    return ~onesSum(tmp, int'(w[0][27:24]));
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".version"}, version, 0);
    checkOutput({tag, ".IHL"}, IHL, 0);
    checkOutput({tag, ".tos"}, type_of_ser, 0);
    checkOutput({tag, ".total_length"}, total_length, 0);
    checkOutput({tag, ".identification"}, identification, 0);
    checkOutput({tag, ".flag"}, flag, 0);
    checkOutput({tag, ".frag_offset"}, frag_offset, 0);
    checkOutput({tag, ".ttl"}, time_to_live, 0);
    checkOutput({tag, ".protocol"}, protocol, 0);
    checkOutput({tag, ".src_ip"}, src_ip, 0);
    checkOutput({tag, ".dest_ip"}, dest_ip, 0);
    checkOutput({tag, ".len_out"}, len_out, 0);
    checkOutput({tag, ".data_out"}, data_out, 0);
    checkOutput({tag, ".wr_en"}, wr_en, 0);
    checkOutput({tag, ".ok"}, ok, 0);
    checkOutput({tag, ".fin"}, fin, 0);
  endtask

  // Feeds a whole packet and checks every cycle against the model, then
  // idles for gap cycles (gap=0 puts the next start in the fin cycle).
  task automatic runPacket(input string name, input logic [31:0] w[$], input int gap);
    int  ihl = int'(w[0][27:24]);
    int  tl  = int'(w[0][15:0]);
    int  len = (tl >= 4 * ihl) ? tl - 4 * ihl : 0;
    bit  exp_ok = (ihl >= 5) && (tl >= 4 * ihl) && (onesSum(w, (ihl < 5) ? 1 : ihl) == 16'hFFFF);
    int  hdr = (ihl < 5) ? 1 : ihl;
    int  pw  = (ihl < 5) ? 0 : (len + 3) / 4;
    int  n   = hdr + pw;
    bit  exp_wr;
    for (int k = 0; k < n; k++) begin
      applyStimulus(k == 0, (k < w.size()) ? w[k] : 32'h0);
      exp_wr = exp_ok && (k >= hdr);
      checkOutput({name, ".wr_en"}, wr_en, exp_wr);
      if (exp_wr) checkOutput({name, ".data_out"}, data_out, w[k]);
      checkOutput({name, ".fin"}, fin, k == n - 1);
      checkOutput({name, ".ok"}, ok, (k >= hdr - 1) ? exp_ok : 1'b0);
    end
    checkOutput({name, ".version"}, version, w[0][31:28]);
    checkOutput({name, ".IHL"}, IHL, w[0][27:24]);
    checkOutput({name, ".tos"}, type_of_ser, w[0][23:16]);
    checkOutput({name, ".total_length"}, total_length, w[0][15:0]);
    checkOutput({name, ".len_out"}, len_out, len);
    if (ihl >= 5) begin
      checkOutput({name, ".identification"}, identification, w[1][31:16]);
      checkOutput({name, ".flag"}, flag, w[1][15:13]);
      checkOutput({name, ".frag_offset"}, frag_offset, w[1][12:0]);
      checkOutput({name, ".ttl"}, time_to_live, w[2][31:24]);
      checkOutput({name, ".protocol"}, protocol, w[2][23:16]);
      checkOutput({name, ".src_ip"}, src_ip, w[3]);
      checkOutput({name, ".dest_ip"}, dest_ip, w[4]);
    end
    for (int g = 0; g < gap; g++) begin
      applyStimulus(1'b0, $urandom);
      checkOutput({name, ".idle_wr_en"}, wr_en, 0);
      checkOutput({name, ".idle_fin"}, fin, 0);
      checkOutput({name, ".idle_ok"}, ok, exp_ok);
    end
  endtask

  initial begin
    logic [31:0] nom[$];
    logic [31:0] bad[$];
    logic [31:0] opt[$];
    logic [31:0] nopay[$];
    logic [31:0] shorth[$];
    logic [31:0] pkt[$];
    int ihl, plen, gap;
    bit good;

    nom = '{32'h4500001F, 32'h12340123, 32'h1011D601, 32'h9801331B,
            32'h980E5E4B, 32'h48656C6C, 32'h6F20576F, 32'h726C6400};
    bad = nom;
    bad[2] = 32'h1011D602;
    opt = '{32'h46000023, 32'h12340123, 32'h10110000, 32'h9801331B,
            32'h980E5E4B, 32'h00000000, 32'h48656C6C, 32'h6F20576F, 32'h726C6400};
    opt[2] = {opt[2][31:16], calcChecksum(opt)};
    nopay = '{32'h45000014, 32'h12340123, 32'h10110000, 32'h9801331B, 32'h980E5E4B};
    nopay[2] = {nopay[2][31:16], calcChecksum(nopay)};
    shorth = '{32'h44000014};

    $display("[TB] reset");
    reset = 1'b0;
    applyStimulus(1'b1, 32'h4500001F);
    applyStimulus(1'b0, 32'h12345678);
    checkAllZero("reset");
    reset = 1'b1;

    $display("[TB] directed packets");
    runPacket("nominal", nom, 1);
    runPacket("bad_chks", bad, 2);
    runPacket("options", opt, 1);
    runPacket("no_payload", nopay, 1);
    runPacket("short_ihl", shorth, 1);

    $display("[TB] reset during second payload word");
    for (int k = 0; k < 6; k++) applyStimulus(k == 0, nom[k]);
    reset = 1'b0;
    applyStimulus(1'b0, nom[6]);
    checkAllZero("midreset");
    reset = 1'b1;
    applyStimulus(1'b0, nom[7]);
    checkOutput("midreset.idle_wr_en", wr_en, 0);
    checkOutput("midreset.idle_fin", fin, 0);
    runPacket("after_reset", nom, 1);

    $display("[TB] back-to-back packets");
    runPacket("b2b_1", nom, 0);
    runPacket("b2b_2", bad, 0);
    runPacket("b2b_3", opt, 0);
    runPacket("b2b_4", nopay, 1);

    $display("[TB] random packets");
    for (int p = 0; p < 30; p++) begin
      ihl  = $urandom_range(5, 8);
      plen = $urandom_range(0, 40);
      gap  = $urandom_range(0, 2);
      good = ($urandom_range(0, 3) != 0);
      pkt.delete();
      pkt.push_back({4'd4, ihl[3:0], 8'($urandom), 16'(4 * ihl + plen)});
      pkt.push_back($urandom);
      pkt.push_back({16'($urandom), 16'h0000});
      for (int i = 3; i < ihl; i++) pkt.push_back($urandom);
      for (int i = 0; i < (plen + 3) / 4; i++) pkt.push_back($urandom);
      pkt[2] = {pkt[2][31:16], calcChecksum(pkt)};
      if (!good) pkt[2] = pkt[2] ^ 32'h1;
      runPacket($sformatf("rand%0d", p), pkt, gap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
